// File: rtl/tow_referee.sv
// Tug of War round/match sequencer: rope position, round wins, scores,
// hold/restart and match-over sequencing for the LED bar and score displays.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset (to IDLE)
//   start                  pulse; begins a match from IDLE or OVER
//   p1_press, p2_press     pulses; pull rope toward index 0 / N_LEDS-1
//   leds                   rope display (one-hot in play, pattern in hold/over)
//   score1, score2         round wins per player
//   round_winner           00 none, 01 player 1, 10 player 2
//   match_over             high while in OVER
//
// Optional macro TOW_PRESS_LOCKOUT_EN adds a per-player press lockout.
module tow_referee #(
    parameter int N_LEDS         = 9,
    parameter int WIN_SCORE      = 3,
    parameter int HOLD_CYCLES    = 50,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              p1_press,
    input  logic              p2_press,
    output logic [N_LEDS-1:0] leds,
    output logic [2:0]        score1,
    output logic [2:0]        score2,
    output logic [1:0]        round_winner,
    output logic              match_over
);

    localparam int PW = $clog2(N_LEDS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [PW-1:0] CTR  = PW'((N_LEDS - 1) / 2);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0] WIN = 3'(WIN_SCORE);
    localparam logic [N_LEDS-1:0] ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

    function automatic logic [N_LEDS-1:0] alt_pat();
        logic [N_LEDS-1:0] p;
        for (int i = 0; i < N_LEDS; i++) p[i] = 1'(i % 2);
        return p;
    endfunction

    localparam logic [N_LEDS-1:0] ALT = alt_pat();

    if (N_LEDS < 3 || (N_LEDS % 2) == 0) begin : g_bad_leds
        $error("tow_referee: N_LEDS must be odd and >= 3");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win
        $error("tow_referee: WIN_SCORE must be 1..7");
    end
    if (HOLD_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cnt
        $error("tow_referee: HOLD_CYCLES and LOCKOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_OVER} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [2:0]        score1_q, score1_d;
    logic [2:0]        score2_q, score2_d;
    logic [1:0]        win_q, win_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              over_q, over_d;

    logic p1_ok, p2_ok;
    logic in_play, mv_left, mv_right, win1, win2;
    logic hold_done, restart;

    assign in_play   = (state_q == S_PLAY);
    assign mv_left   = in_play && p1_ok && !p2_ok;
    assign mv_right  = in_play && p2_ok && !p1_ok;
    assign win1      = mv_left && (pos_q == '0);
    assign win2      = mv_right && (pos_q == LAST);
    assign hold_done = (state_q == S_HOLD) && (hold_q == HOLD_LAST);
    assign restart   = start && (state_q == S_IDLE || state_q == S_OVER);

`ifdef TOW_PRESS_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    // The accepting cycle is the first locked cycle, so the register
    // holds the remaining LOCKOUT_CYCLES-1 cycles.
    localparam logic [LW-1:0] LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic [LW-1:0] lock1_q, lock1_d, lock2_q, lock2_d;

    assign p1_ok = p1_press && (lock1_q == '0);
    assign p2_ok = p2_press && (lock2_q == '0);

    always_comb begin
        lock1_d = lock1_q;
        lock2_d = lock2_q;
        if (lock1_q != '0) lock1_d = lock1_q - LW'(1);
        if (lock2_q != '0) lock2_d = lock2_q - LW'(1);
        // A cancelled press still counts as accepted.
        if (in_play && p1_ok) lock1_d = LOAD;
        if (in_play && p2_ok) lock2_d = LOAD;
        if (restart || hold_done) begin
            lock1_d = '0;
            lock2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock1_q <= '0;
            lock2_q <= '0;
        end else begin
            lock1_q <= lock1_d;
            lock2_q <= lock2_d;
        end
    end
`else
    assign p1_ok = p1_press;
    assign p2_ok = p2_press;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pos_q    <= CTR;
            score1_q <= '0;
            score2_q <= '0;
            win_q    <= '0;
            hold_q   <= '0;
            leds_q   <= ONE << CTR;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            leds_q   <= leds_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        score1_d = score1_q;
        score2_d = score2_q;
        win_d    = win_q;
        hold_d   = hold_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_PLAY;
                    pos_d    = CTR;
                    score1_d = '0;
                    score2_d = '0;
                    win_d    = 2'b00;
                end
            end
            S_PLAY: begin
                if (win1) begin
                    score1_d = score1_q + 3'd1;
                    win_d    = 2'b01;
                    hold_d   = '0;
                    state_d  = (score1_d == WIN) ? S_OVER : S_HOLD;
                end else if (win2) begin
                    score2_d = score2_q + 3'd1;
                    win_d    = 2'b10;
                    hold_d   = '0;
                    state_d  = (score2_d == WIN) ? S_OVER : S_HOLD;
                end else if (mv_left) begin
                    pos_d = pos_q - PW'(1);
                end else if (mv_right) begin
                    pos_d = pos_q + PW'(1);
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    state_d = S_PLAY;
                    pos_d   = CTR;
                    win_d   = 2'b00;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next-state values so they change
    // on the same edge as the state they describe.
    always_comb begin
        leds_d = ONE << CTR;
        over_d = (state_d == S_OVER);
        unique case (state_d)
            S_IDLE: leds_d = ONE << CTR;
            S_PLAY: leds_d = ONE << pos_d;
            S_HOLD, S_OVER: leds_d = (win_d == 2'b01) ? '1 : ALT;
            default: ;
        endcase
    end

    assign leds         = leds_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign round_winner = win_q;
    assign match_over   = over_q;

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: rope walk, hold timing, cancel,
// match over/restart, mid-round reset and (optionally) press lockout.
module tb_tow_referee;

    localparam int HOLD = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       p1_press = 1'b0;
    logic       p2_press = 1'b0;
    logic [8:0] leds;
    logic [2:0] score1, score2;
    logic [1:0] round_winner;
    logic       match_over;

    int tests = 0;
    int fails = 0;

    logic [17:0] obs;
    logic [17:0] exp;

    localparam logic [8:0] C4  = 9'b000010000;
    localparam logic [8:0] ALL = 9'b111111111;
    localparam logic [8:0] ALT = 9'b010101010;

    tow_referee #(
        .N_LEDS(9), .WIN_SCORE(3), .HOLD_CYCLES(HOLD), .LOCKOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_press(p1_press), .p2_press(p2_press),
        .leds(leds), .score1(score1), .score2(score2),
        .round_winner(round_winner), .match_over(match_over)
    );

    always #5 clk = ~clk;

    assign obs = {leds, score1, score2, round_winner, match_over};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input logic s);
        p1_press = a;
        p2_press = b;
        start    = s;
        tick();
        p1_press = 1'b0;
        p2_press = 1'b0;
        start    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_state got %h want %h", obs, exp);
        end
        drive(1, 0, 0);
        drive(0, 1, 0);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL idle_ignores_press got %h want %h", obs, exp);
        end
    endtask

    task automatic test_walk();
        logic [8:0] want;
        drive(0, 0, 1);
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL start_centre got %h want %h", obs, exp);
        end
        want = C4;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0);
            want = want >> 1;
            exp = {want, 3'd0, 3'd0, 2'b00, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL walk_%0d got %h want %h", i, obs, exp);
            end
        end
        drive(1, 0, 0);
        exp = {ALL, 3'd1, 3'd0, 2'b01, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL p1_round_win got %h want %h", obs, exp);
        end
    endtask

    task automatic test_hold();
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 1);
        exp = {ALL, 3'd1, 3'd0, 2'b01, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL hold_ignores got %h want %h", obs, exp);
        end
        idle(HOLD - 4);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL hold_last_cycle got %h want %h", obs, exp);
        end
        tick();
        exp = {C4, 3'd1, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL hold_exit got %h want %h", obs, exp);
        end
    endtask

    task automatic test_cancel();
        drive(1, 1, 0);
        exp = {C4, 3'd1, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL cancel got %h want %h", obs, exp);
        end
        drive(0, 1, 0);
        exp = {9'b000100000, 3'd1, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL p2_after_cancel got %h want %h", obs, exp);
        end
    endtask

    task automatic test_match_over();
        for (int i = 0; i < 4; i++) drive(0, 1, 0);
        exp = {ALT, 3'd1, 3'd1, 2'b10, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL p2_round1 got %h want %h", obs, exp);
        end
        idle(HOLD);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        exp = {ALT, 3'd1, 3'd2, 2'b10, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL p2_round2 got %h want %h", obs, exp);
        end
        idle(HOLD);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        exp = {ALT, 3'd1, 3'd3, 2'b10, 1'b1};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL match_over got %h want %h", obs, exp);
        end
        drive(1, 0, 0);
        drive(0, 1, 0);
        idle(HOLD + 5);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL over_frozen got %h want %h", obs, exp);
        end
        drive(0, 0, 1);
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL over_restart got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) drive(1, 0, 0);
            idle(HOLD);
        end
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        exp = {9'b000000010, 3'd2, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL pre_reset got %h want %h", obs, exp);
        end
        reset = 1'b1;
        drive(1, 0, 1);
        reset = 1'b0;
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL mid_reset got %h want %h", obs, exp);
        end
        drive(1, 0, 0);
        drive(1, 0, 0);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL post_reset_idle got %h want %h", obs, exp);
        end
    endtask

`ifdef TOW_PRESS_LOCKOUT_EN
    task automatic test_lockout();
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(0, 1, 0);
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL lock_p2_moves got %h want %h", obs, exp);
        end
        drive(1, 0, 0);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL lock_drop got %h want %h", obs, exp);
        end
        tick();
        drive(1, 0, 0);
        exp = {9'b000001000, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL lock_expire got %h want %h", obs, exp);
        end
        drive(1, 1, 0);
        exp = {C4, 3'd0, 3'd0, 2'b00, 1'b0};
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL lock_no_cancel got %h want %h", obs, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_walk();
        test_hold();
        test_cancel();
        test_match_over();
        test_reset_mid();
`ifdef TOW_PRESS_LOCKOUT_EN
        test_lockout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
